// File: rtl/usb_ctrl_pkg.sv
// usb_ctrl_pkg: shared PID codes, FSM state encodings, debug struct and
// default parameters for the USB endpoint protocol sequencer.
package usb_ctrl_pkg;

  // Decoded RX PIDs delivered by the receive path
  localparam logic [3:0] RXP_IDLE  = 4'd0;
  localparam logic [3:0] RXP_OUT   = 4'd1;
  localparam logic [3:0] RXP_IN    = 4'd2;
  localparam logic [3:0] RXP_DATA0 = 4'd3;
  localparam logic [3:0] RXP_ACK   = 4'd4;
  localparam logic [3:0] RXP_NAK   = 4'd5;

  // Packet codes handed to the transmit engine
  localparam logic [3:0] TXP_IDLE  = 4'd0;
  localparam logic [3:0] TXP_DATA0 = 4'd1;
  localparam logic [3:0] TXP_ACK   = 4'd2;
  localparam logic [3:0] TXP_NAK   = 4'd3;
  localparam logic [3:0] TXP_STALL = 4'd4;

  // Sequencer states
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_RX_DATA   = 3'd1;
  localparam state_t ST_SEND_HS   = 3'd2;
  localparam state_t ST_SEND_DATA = 3'd3;
  localparam state_t ST_TX_WAIT   = 3'd4;
  localparam state_t ST_ACK_WAIT  = 3'd5;

  // Default sizing
  localparam int unsigned DEF_TIMEOUT_CYC = 144;
  localparam int unsigned DEF_MAX_OCC     = 64;

  // Observable internals for checkers
  typedef struct packed {
    state_t state;
    logic   rx_busy;
    logic   tx_busy;
    logic   halt;
  } ctrl_dbg_t;

  // NAK and STALL both refuse the transaction and both raise nak_sent
  function automatic logic is_refusal(input logic [3:0] code);
    return (code == TXP_NAK) || (code == TXP_STALL);
  endfunction

endpackage

// File: rtl/usb_protocol_ctrl_if.sv
// usb_protocol_ctrl_if: RX/TX/AHB-side signals of the protocol sequencer.
// master = the sequencer, slave = the PHY engines and AHB status logic.
// Handshake: rx_data_ready, rx_error, tx_error, tx_start and all status
// outputs are single-cycle pulses with no back-pressure; rx_packet is
// valid only while rx_data_ready is high and tx_packet only while tx_start
// is high. tx_data_pend and the *_active signals are levels.
interface usb_protocol_ctrl_if;
  import usb_ctrl_pkg::*;

  logic [3:0] rx_packet;
  logic       rx_data_ready;
  logic       rx_transfer_active;
  logic       rx_error;
  logic       tx_transfer_active;
  logic       tx_error;
  logic [6:0] buffer_occupancy;
  logic       tx_data_pend;
  logic       ep_halt;
  logic [3:0] tx_packet;
  logic       tx_start;
  logic       d_mode;
  logic       clear_buffer;
  logic       rx_done;
  logic       tx_done;
  logic       nak_sent;
  logic       timeout_err;
  ctrl_dbg_t  dbg;

  modport master (
    input  rx_packet, rx_data_ready, rx_transfer_active, rx_error,
           tx_transfer_active, tx_error, buffer_occupancy, tx_data_pend, ep_halt,
    output tx_packet, tx_start, d_mode, clear_buffer, rx_done, tx_done,
           nak_sent, timeout_err, dbg
  );

  modport slave (
    output rx_packet, rx_data_ready, rx_transfer_active, rx_error,
           tx_transfer_active, tx_error, buffer_occupancy, tx_data_pend, ep_halt,
    input  tx_packet, tx_start, d_mode, clear_buffer, rx_done, tx_done,
           nak_sent, timeout_err, dbg
  );
endinterface

// File: rtl/usb_ctrl_timeout.sv
// usb_ctrl_timeout: saturating cycle counter with synchronous clear and a
// terminal-count flag raised while enabled on count TIMEOUT_CYC-1.
module usb_ctrl_timeout #(
  parameter int unsigned TIMEOUT_CYC = 144
) (
  input  logic clk,
  input  logic n_rst,
  input  logic en,
  input  logic clr,
  output logic tc
);
  localparam int W = $clog2(TIMEOUT_CYC);

  logic [W-1:0] cnt_q, cnt_d;

  // Clear wins; otherwise count while enabled, holding at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (clr)                      cnt_d = '0;
    else if (en && cnt_q != '1)   cnt_d = cnt_q + 1'b1;
  end

  // Counter register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc = en && (cnt_q == W'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/usb_protocol_ctrl.sv
// usb_protocol_ctrl: endpoint protocol sequencer. Turns decoded RX packets
// into handshake/data launches, owns bus direction and the host-ACK timeout.
// Optional build macro USB_CTRL_STALL_EN: when defined, a halted endpoint
// answers IN and OUT-DATA0 with STALL; otherwise ep_halt has no effect.
module usb_protocol_ctrl
  import usb_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int unsigned MAX_OCC     = DEF_MAX_OCC
) (
  input logic               clk,
  input logic               n_rst,
  usb_protocol_ctrl_if.master bus
);
`ifdef USB_CTRL_STALL_EN
  localparam logic STALL_EN = 1'b1;
`else
  localparam logic STALL_EN = 1'b0;
`endif
  localparam logic [6:0] MAX_OCC_C = 7'(MAX_OCC);

  state_t     state_q, state_d;
  logic [3:0] tx_packet_q, tx_packet_d;
  logic       tx_start_q, tx_start_d;
  logic       d_mode_q, d_mode_d;
  logic       clear_q, clear_d;
  logic       rx_done_q, rx_done_d;
  logic       tx_done_q, tx_done_d;
  logic       nak_q, nak_d;
  logic       tout_q, tout_d;
  logic       data_sent_q, data_sent_d;
  logic       txa_prev_q, txa_prev_d;
  logic       halt, rx_ok, tx_fall, tmr_clr, tmr_en, tmr_tc;

  assign halt    = STALL_EN & bus.ep_halt;
  // rx_error suppresses a coincident rx_data_ready
  assign rx_ok   = bus.rx_data_ready & ~bus.rx_error;
  assign tx_fall = txa_prev_q & ~bus.tx_transfer_active;
  assign txa_prev_d = bus.tx_transfer_active;
  assign tmr_en  = (state_q == ST_ACK_WAIT);
  assign tmr_clr = (state_d == ST_ACK_WAIT) && (state_q != ST_ACK_WAIT);

  usb_ctrl_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk   (clk),
    .n_rst (n_rst),
    .en    (tmr_en),
    .clr   (tmr_clr),
    .tc    (tmr_tc)
  );

  // Next state plus registered (Moore) pulse outputs for the next cycle
  always_comb begin
    state_d     = state_q;
    tx_packet_d = TXP_IDLE;
    tx_start_d  = 1'b0;
    d_mode_d    = d_mode_q;
    clear_d     = 1'b0;
    rx_done_d   = 1'b0;
    tx_done_d   = 1'b0;
    nak_d       = 1'b0;
    tout_d      = 1'b0;
    data_sent_d = data_sent_q;
    case (state_q)
      ST_IDLE: begin
        d_mode_d = 1'b0;
        if (rx_ok && bus.rx_packet == RXP_OUT) begin
          state_d = ST_RX_DATA;
        end else if (rx_ok && bus.rx_packet == RXP_IN) begin
          tx_start_d = 1'b1;
          d_mode_d   = 1'b1;
          if (halt)                  tx_packet_d = TXP_STALL;
          else if (bus.tx_data_pend) tx_packet_d = TXP_DATA0;
          else                       tx_packet_d = TXP_NAK;
          state_d = (tx_packet_d == TXP_DATA0) ? ST_SEND_DATA : ST_SEND_HS;
          nak_d   = is_refusal(tx_packet_d);
        end
      end
      ST_RX_DATA: begin
        if (bus.rx_error || (rx_ok && bus.rx_packet != RXP_DATA0)) begin
          clear_d = 1'b1;
          state_d = ST_IDLE;
        end else if (rx_ok) begin
          state_d    = ST_SEND_HS;
          tx_start_d = 1'b1;
          d_mode_d   = 1'b1;
          if (halt) begin
            tx_packet_d = TXP_STALL;
            clear_d     = 1'b1;
          end else if (bus.buffer_occupancy < MAX_OCC_C) begin
            tx_packet_d = TXP_ACK;
            rx_done_d   = 1'b1;
          end else begin
            tx_packet_d = TXP_NAK;
            clear_d     = 1'b1;
          end
          nak_d = is_refusal(tx_packet_d);
        end
      end
      ST_SEND_HS: begin
        data_sent_d = 1'b0;
        state_d     = ST_TX_WAIT;
      end
      ST_SEND_DATA: begin
        data_sent_d = 1'b1;
        state_d     = ST_TX_WAIT;
      end
      ST_TX_WAIT: begin
        if (bus.tx_error) begin
          d_mode_d    = 1'b0;
          data_sent_d = 1'b0;
          state_d     = ST_IDLE;
        end else if (tx_fall) begin
          d_mode_d = 1'b0;
          state_d  = data_sent_q ? ST_ACK_WAIT : ST_IDLE;
        end
      end
      ST_ACK_WAIT: begin
        if (bus.rx_error) begin
          state_d = ST_IDLE;
        end else if (rx_ok && bus.rx_packet == RXP_ACK) begin
          tx_done_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (rx_ok && bus.rx_packet == RXP_NAK) begin
          state_d = ST_IDLE;
        end else if (tmr_tc) begin
          tout_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any transaction silently
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      tx_packet_q <= TXP_IDLE;
      tx_start_q  <= 1'b0;
      d_mode_q    <= 1'b0;
      clear_q     <= 1'b0;
      rx_done_q   <= 1'b0;
      tx_done_q   <= 1'b0;
      nak_q       <= 1'b0;
      tout_q      <= 1'b0;
      data_sent_q <= 1'b0;
      txa_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_packet_q <= tx_packet_d;
      tx_start_q  <= tx_start_d;
      d_mode_q    <= d_mode_d;
      clear_q     <= clear_d;
      rx_done_q   <= rx_done_d;
      tx_done_q   <= tx_done_d;
      nak_q       <= nak_d;
      tout_q      <= tout_d;
      data_sent_q <= data_sent_d;
      txa_prev_q  <= txa_prev_d;
    end
  end

  assign bus.tx_packet    = tx_packet_q;
  assign bus.tx_start     = tx_start_q;
  assign bus.d_mode       = d_mode_q;
  assign bus.clear_buffer = clear_q;
  assign bus.rx_done      = rx_done_q;
  assign bus.tx_done      = tx_done_q;
  assign bus.nak_sent     = nak_q;
  assign bus.timeout_err  = tout_q;
  assign bus.dbg = '{state: state_q, rx_busy: bus.rx_transfer_active,
                     tx_busy: bus.tx_transfer_active, halt: bus.ep_halt};
endmodule

// File: tb/tb_usb_protocol_ctrl.sv
// tb_usb_protocol_ctrl: directed scenarios for the USB protocol sequencer.
// Launch records {tx_start, tx_packet, rx_done, nak_sent, clear_buffer} are
// queued when the triggering packet is driven and popped one clock later.
module tb_usb_protocol_ctrl;
  import usb_ctrl_pkg::*;

  localparam int W = 8;

  logic clk;
  logic n_rst;
  int   total = 0;
  int   bad   = 0;
  logic [W-1:0] exp_q[$];

  usb_protocol_ctrl_if bus();

  usb_protocol_ctrl dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver / monitor tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rx(input logic [3:0] pid, input logic rdy, input logic err);
    step();
    bus.rx_packet     = pid;
    bus.rx_data_ready = rdy;
    bus.rx_error      = err;
    step();
    bus.rx_packet     = RXP_IDLE;
    bus.rx_data_ready = 1'b0;
    bus.rx_error      = 1'b0;
  endtask

  function automatic logic [W-1:0] launch_rec();
    return {bus.tx_start, bus.tx_packet, bus.rx_done, bus.nak_sent, bus.clear_buffer};
  endfunction

  // TX engine: busy for len cycles after the SEND cycle; counts d_mode drops
  task automatic run_tx(input int len, output int dm_bad);
    dm_bad = 0;
    step();
    bus.tx_transfer_active = 1'b1;
    for (int i = 0; i < len; i++) begin
      step();
      if (bus.d_mode !== 1'b1) dm_bad++;
    end
    bus.tx_transfer_active = 1'b0;
    step();
  endtask

  task automatic apply_reset();
    n_rst                  = 1'b0;
    bus.rx_packet          = RXP_IDLE;
    bus.rx_data_ready      = 1'b0;
    bus.rx_transfer_active = 1'b0;
    bus.rx_error           = 1'b0;
    bus.tx_transfer_active = 1'b0;
    bus.tx_error           = 1'b0;
    bus.buffer_occupancy   = 7'd0;
    bus.tx_data_pend       = 1'b0;
    bus.ep_halt            = 1'b0;
    repeat (3) step();
    n_rst = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [10:0] outs;
    apply_reset();
    outs = {bus.tx_start, bus.tx_packet, bus.d_mode, bus.clear_buffer, bus.rx_done,
            bus.tx_done, bus.nak_sent, bus.timeout_err};
    total++;
    if (outs !== 11'd0) begin
      bad++; $display("FAIL reset_outputs got=%h exp=0", outs);
    end
    total++;
    if (bus.dbg.state !== ST_IDLE) begin
      bad++; $display("FAIL reset_state got=%0d exp=%0d", bus.dbg.state, ST_IDLE);
    end
  endtask

  task automatic test_out_ack();
    logic [W-1:0] got, exp;
    int dm_bad;
    bus.buffer_occupancy = 7'd8;
    drive_rx(RXP_OUT, 1'b1, 1'b0);
    total++;
    if (bus.tx_start !== 1'b0) begin
      bad++; $display("FAIL out_token_no_launch got=%b exp=0", bus.tx_start);
    end
    drive_rx(RXP_DATA0, 1'b1, 1'b0);
    exp_q.push_back({1'b1, TXP_ACK, 1'b1, 1'b0, 1'b0});
    got = launch_rec();
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) begin
      bad++; $display("FAIL out_ack_launch got=%h exp=%h", got, exp);
    end
    total++;
    if (bus.d_mode !== 1'b1) begin
      bad++; $display("FAIL out_ack_dmode_on got=%b exp=1", bus.d_mode);
    end
    run_tx(5, dm_bad);
    total++;
    if (dm_bad !== 0) begin
      bad++; $display("FAIL out_ack_dmode_hold got=%0d drops exp=0", dm_bad);
    end
    total++;
    if ({bus.d_mode, bus.dbg.state} !== {1'b0, ST_IDLE}) begin
      bad++; $display("FAIL out_ack_release got=%b/%0d exp=0/0", bus.d_mode, bus.dbg.state);
    end
  endtask

  task automatic test_out_nak();
    logic [W-1:0] got, exp;
    int dm_bad;
    bus.buffer_occupancy = 7'd64;
    drive_rx(RXP_OUT, 1'b1, 1'b0);
    drive_rx(RXP_DATA0, 1'b1, 1'b0);
    exp_q.push_back({1'b1, TXP_NAK, 1'b0, 1'b1, 1'b1});
    got = launch_rec();
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) begin
      bad++; $display("FAIL out_full_nak got=%h exp=%h", got, exp);
    end
    run_tx(3, dm_bad);
  endtask

  task automatic test_in_nak();
    logic [W-1:0] got, exp;
    int dm_bad;
    bus.tx_data_pend = 1'b0;
    drive_rx(RXP_IN, 1'b1, 1'b0);
    exp_q.push_back({1'b1, TXP_NAK, 1'b0, 1'b1, 1'b0});
    got = launch_rec();
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) begin
      bad++; $display("FAIL in_nak got=%h exp=%h", got, exp);
    end
    run_tx(3, dm_bad);
    total++;
    if (bus.dbg.state !== ST_IDLE) begin
      bad++; $display("FAIL in_nak_idle got=%0d exp=%0d", bus.dbg.state, ST_IDLE);
    end
  endtask

  task automatic test_in_data_ack();
    logic [W-1:0] got, exp;
    int dm_bad;
    int n_done;
    bus.tx_data_pend = 1'b1;
    drive_rx(RXP_IN, 1'b1, 1'b0);
    exp_q.push_back({1'b1, TXP_DATA0, 1'b0, 1'b0, 1'b0});
    got = launch_rec();
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) begin
      bad++; $display("FAIL in_data_launch got=%h exp=%h", got, exp);
    end
    run_tx(8, dm_bad);
    total++;
    if (bus.dbg.state !== ST_ACK_WAIT) begin
      bad++; $display("FAIL in_data_ackwait got=%0d exp=%0d", bus.dbg.state, ST_ACK_WAIT);
    end
    repeat (3) step();
    drive_rx(RXP_ACK, 1'b1, 1'b0);
    n_done = int'(bus.tx_done);
    bus.tx_data_pend = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      n_done += int'(bus.tx_done);
    end
    total++;
    if (n_done !== 1) begin
      bad++; $display("FAIL in_data_tx_done_count got=%0d exp=1", n_done);
    end
  endtask

  task automatic test_timeout();
    logic [W-1:0] got, exp;
    int dm_bad;
    int aw_cyc, n_done;
    bit seen;
    bus.tx_data_pend = 1'b1;
    drive_rx(RXP_IN, 1'b1, 1'b0);
    exp_q.push_back({1'b1, TXP_DATA0, 1'b0, 1'b0, 1'b0});
    got = launch_rec();
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) begin
      bad++; $display("FAIL timeout_launch got=%h exp=%h", got, exp);
    end
    run_tx(4, dm_bad);
    aw_cyc = 0; n_done = 0; seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (bus.dbg.state == ST_ACK_WAIT) aw_cyc++;
      n_done += int'(bus.tx_done);
      if (bus.timeout_err) seen = 1'b1;
      else step();
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL timeout_seen got=0 exp=1 (budget expired)");
    end
    total++;
    if (aw_cyc !== 144) begin
      bad++; $display("FAIL timeout_cycles got=%0d exp=144", aw_cyc);
    end
    total++;
    if ({n_done, bus.dbg.state} !== {32'd0, ST_IDLE}) begin
      bad++; $display("FAIL timeout_end got=done%0d/st%0d exp=done0/st0", n_done, bus.dbg.state);
    end
    bus.tx_data_pend = 1'b0;
    step();
  endtask

  task automatic test_rx_error();
    logic [W-1:0] got, exp;
    drive_rx(RXP_OUT, 1'b1, 1'b0);
    drive_rx(RXP_DATA0, 1'b0, 1'b1);
    exp_q.push_back({1'b0, TXP_IDLE, 1'b0, 1'b0, 1'b1});
    got = launch_rec();
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) begin
      bad++; $display("FAIL rx_error_flush got=%h exp=%h", got, exp);
    end
    total++;
    if (bus.dbg.state !== ST_IDLE) begin
      bad++; $display("FAIL rx_error_idle got=%0d exp=0", bus.dbg.state);
    end
    // rx_error must win over a coincident IN
    drive_rx(RXP_IN, 1'b1, 1'b1);
    exp_q.push_back({1'b0, TXP_IDLE, 1'b0, 1'b0, 1'b0});
    got = launch_rec();
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) begin
      bad++; $display("FAIL rx_error_priority got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] outs;
    drive_rx(RXP_IN, 1'b1, 1'b0);
    step();
    bus.tx_transfer_active = 1'b1;
    step();
    total++;
    if ({bus.d_mode, bus.dbg.state} !== {1'b1, ST_TX_WAIT}) begin
      bad++; $display("FAIL mid_reset_pre got=%b/%0d exp=1/%0d", bus.d_mode, bus.dbg.state, ST_TX_WAIT);
    end
    #2 n_rst = 1'b0;
    step();
    outs = {bus.tx_start, bus.tx_packet, bus.d_mode, bus.clear_buffer, bus.rx_done,
            bus.tx_done, bus.nak_sent, bus.timeout_err};
    total++;
    if ({outs, bus.dbg.state} !== {11'd0, ST_IDLE}) begin
      bad++; $display("FAIL mid_reset_outputs got=%h/%0d exp=0/0", outs, bus.dbg.state);
    end
    bus.tx_transfer_active = 1'b0;
    n_rst = 1'b1;
    step();
  endtask

  task automatic test_stall();
    logic [W-1:0] got, exp;
    logic [3:0] exp_pkt;
    int dm_bad;
`ifdef USB_CTRL_STALL_EN
    exp_pkt = TXP_STALL;
`else
    exp_pkt = TXP_NAK;
`endif
    bus.ep_halt      = 1'b1;
    bus.tx_data_pend = 1'b0;
    drive_rx(RXP_IN, 1'b1, 1'b0);
    exp_q.push_back({1'b1, exp_pkt, 1'b0, 1'b1, 1'b0});
    got = launch_rec();
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) begin
      bad++; $display("FAIL halt_in got=%h exp=%h", got, exp);
    end
    run_tx(3, dm_bad);
    bus.ep_halt = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] got, exp;
    logic [6:0] occ;
    int dm_bad;
    for (int n = 0; n < 8; n++) begin
      occ = 7'($urandom_range(0, 127));
      if (n == 0) occ = 7'd63;
      if (n == 1) occ = 7'd64;
      bus.buffer_occupancy = occ;
      drive_rx(RXP_OUT, 1'b1, 1'b0);
      drive_rx(RXP_DATA0, 1'b1, 1'b0);
      if (occ < 7'd64) exp_q.push_back({1'b1, TXP_ACK, 1'b1, 1'b0, 1'b0});
      else             exp_q.push_back({1'b1, TXP_NAK, 1'b0, 1'b1, 1'b1});
      got = launch_rec();
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL b2b_out[%0d] occ=%0d got=%h exp=%h", n, occ, got, exp);
      end
      run_tx(int'($urandom_range(1, 6)), dm_bad);
      total++;
      if (dm_bad !== 0 || bus.dbg.state !== ST_IDLE) begin
        bad++; $display("FAIL b2b_release[%0d] got=drops%0d/st%0d exp=drops0/st0", n, dm_bad, bus.dbg.state);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_out_ack();
    test_out_nak();
    test_in_nak();
    test_in_data_ack();
    test_timeout();
    test_rx_error();
    test_reset_mid();
    test_stall();
    test_back_to_back();
    total++;
    if (exp_q.size() !== 0) begin
      bad++; $display("FAIL scoreboard_drain got=%0d left exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
